fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end for the LEGv8 64-bit processor. It sits directly upstream of the decode/register-read/execute datapath.
- Owns the program counter. Drives the address to the instruction memory and latches the fetched word into an IF/ID pipeline register.
- Downstream consumes if_id_instr/if_id_pc. Downstream feeds back stall, flush and resolved-branch redirects.
- Includes a boot/run/halt state machine and a retired-fetch counter.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, bubble word written into IF/ID on squash.
- HALT_INSTR, 32'hD4400000, encoding that stops fetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  64  fetch address (equals PC), to instruction memory.
- imem_instr  input  32  instruction word, combinational read of imem_addr.
- stall  input  1  hold PC and IF/ID (load-use hazard).
- flush  input  1  squash IF/ID contents.
- br_taken  input  1  resolved taken branch from downstream.
- br_target  input  64  branch target address, valid when br_taken=1.
- if_id_pc  output  64  PC of the instruction in IF/ID.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped on HALT_INSTR.
- misalign_err  output  1  sticky flag: a branch target had nonzero bits [1:0].
- fetch_count  output  32  number of valid instructions written into IF/ID.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Every register updates only on posedge clk.
- Reset values:
  - PC=RESET_PC, state=BOOT.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0.
- imem_addr is combinationally equal to PC. Fetch latency from PC to IF/ID is 1 cycle.
- State BOOT:
  - Lasts exactly one cycle after reset is released.
  - IF/ID gets a bubble and PC is held.
  - Next state is RUN.
  - This provides one settle cycle for the instruction memory.
- State RUN, evaluated in this priority order:
  1. br_taken=1:
     - PC <= {br_target[63:2],2'b00}.
     - IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc unchanged).
     - misalign_err is set if br_target[1:0]!=0.
     - This applies regardless of stall and flush.
  2. flush=1 (without br_taken):
     - IF/ID <= bubble.
     - PC held, so the same address is re-fetched next cycle.
  3. stall=1:
     - PC and all IF/ID fields hold their values.
     - fetch_count holds.
  4. imem_instr==HALT_INSTR:
     - IF/ID <= bubble and PC held.
     - Next state is HALTED and halted=1.
     - The halt word itself is never passed downstream.
  5. Otherwise:
     - IF/ID <= {PC, imem_instr, valid=1}.
     - PC <= PC+4; wraps modulo 2^64.
     - fetch_count += 1; wraps at 2^32.
- State HALTED:
  - PC is frozen and IF/ID holds a bubble.
  - stall and flush are ignored.
  - br_taken=1: an older in-flight branch proves the halt was wrong-path. PC <= target, state=RUN, halted=0, IF/ID stays a bubble.
  - Only reset or br_taken leaves HALTED.
- misalign_err is sticky and is cleared only by reset.
- Reset asserted mid-operation, including mid-stall or while HALTED, overrides every other input in that cycle.
- There are no combinational paths from stall, flush or br_taken to any output. All outputs are registered except imem_addr, which is PC-registered.

Test Plan:
- Reset, then release with imem returning word i*4 at address i*4:
  - Cycle 1 after release: valid=0 (BOOT).
  - Following cycles: if_id_pc = 0, 4, 8, … with matching instr.
  - fetch_count = 3 after 3 fetches.
- Stall for 2 cycles at PC=8: IF/ID holds pc=4 and imem_addr stays 8 throughout; fetch resumes at 8 with no skipped and no duplicated instructions.
- br_taken=1, br_target=0x100, with stall=1 in the same cycle:
  - Next cycle: imem_addr=0x100, if_id_valid=0, fetch_count unchanged.
  - Following cycle: if_id_pc=0x100.
- br_target=0x102: PC becomes 0x100, misalign_err=1, and the flag remains set through further branches until reset.
- HALT_INSTR at address 0x10:
  - halted=1, if_id_valid=0, imem_addr frozen at 0x10 for 5+ cycles.
  - Then br_taken to 0x40 gives halted=0 and fetch at 0x40.
- Reset asserted while HALTED and while stalled: all outputs return to their reset values on the next edge and PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch front end: owns the PC, drives instruction memory and
// fills the IF/ID register. Includes a boot/run/halt controller and a fetch counter.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
  parameter logic [31:0] HALT_INSTR = 32'hD4400000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;

  assign imem_addr = pc;

  // NOTE: every register below is assigned with <= so all state updates see
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_id_pc     <= 64'h0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      unique case (state)
        BOOT: begin
          // One settle cycle for the instruction memory before the first fetch.
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          if (br_taken) begin
            pc          <= {br_target[63:2], 2'b00};
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (br_target[1:0] != 2'b00) misalign_err <= 1'b1;
          end else if (flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            // Hold PC, IF/ID and the counter.
          end else if (imem_instr == HALT_INSTR) begin
            // The halt word is swallowed here and never reaches decode.
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= HALTED;
          end else begin
            if_id_pc    <= pc;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
            pc          <= pc + 64'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end

        HALTED: begin
          // A resolved older branch means the halt word was on the wrong path.
          if (br_taken) begin
            pc     <= {br_target[63:2], 2'b00};
            halted <= 1'b0;
            state  <= RUN;
            if (br_target[1:0] != 2'b00) misalign_err <= 1'b1;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns the address as the word, with an
// optional HALT_INSTR planted at 0x10.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] HALT = 32'hD4400000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall, flush, br_taken;
  logic [63:0] br_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid, halted, misalign_err;
  logic [31:0] fetch_count;
  logic        halt_en;

  int compared   = 0;
  int mismatched = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .misalign_err(misalign_err),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = (halt_en && imem_addr == 64'h10) ? HALT : imem_addr[31:0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  imem_addr, 64'h0);
    check({tag, "_pc"},    if_id_pc, 64'h0);
    check({tag, "_instr"}, {32'h0, if_id_instr}, {32'h0, NOP});
    check({tag, "_valid"}, {63'h0, if_id_valid}, 64'h0);
    check({tag, "_halt"},  {63'h0, halted}, 64'h0);
    check({tag, "_mis"},   {63'h0, misalign_err}, 64'h0);
    check({tag, "_cnt"},   {32'h0, fetch_count}, 64'h0);
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic valid,
                            input logic [31:0] cnt);
    check({tag, "_pc"},    if_id_pc, pc);
    check({tag, "_valid"}, {63'h0, if_id_valid}, {63'h0, valid});
    check({tag, "_cnt"},   {32'h0, fetch_count}, {32'h0, cnt});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    br_target = 64'h0; halt_en = 1'b0;
    step(); step();
    check_reset_state("rst");

    // Boot cycle, then sequential fetch.
    reset = 1'b0;
    step();
    check("boot_valid", {63'h0, if_id_valid}, 64'h0);
    check("boot_addr", imem_addr, 64'h0);
    step();
    check_ifid("f0", 64'h0, 1'b1, 32'd1);
    check("f0_instr", {32'h0, if_id_instr}, 64'h0);
    step();
    check_ifid("f4", 64'h4, 1'b1, 32'd2);
    check("f4_instr", {32'h0, if_id_instr}, 64'h4);
    check("f4_addr", imem_addr, 64'h8);

    // Two-cycle stall at PC=8.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("stall", 64'h4, 1'b1, 32'd2);
      check("stall_addr", imem_addr, 64'h8);
    end
    stall = 1'b0;
    step();
    check_ifid("f8", 64'h8, 1'b1, 32'd3);
    check("f8_instr", {32'h0, if_id_instr}, 64'h8);

    // Branch wins over a simultaneous stall.
    br_taken = 1'b1; br_target = 64'h100; stall = 1'b1;
    step();
    check("br_addr", imem_addr, 64'h100);
    check_ifid("br", 64'h8, 1'b0, 32'd3);
    check("br_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    br_taken = 1'b0; stall = 1'b0;
    step();
    check_ifid("f100", 64'h100, 1'b1, 32'd4);
    check("f100_instr", {32'h0, if_id_instr}, 64'h100);

    // Flush bubbles IF/ID and refetches the same address.
    flush = 1'b1;
    step();
    check_ifid("flush", 64'h100, 1'b0, 32'd4);
    check("flush_addr", imem_addr, 64'h104);
    flush = 1'b0;
    step();
    check_ifid("f104", 64'h104, 1'b1, 32'd5);

    // Misaligned target is aligned down and the error is sticky.
    br_taken = 1'b1; br_target = 64'h102;
    step();
    check("mis_addr", imem_addr, 64'h100);
    check("mis_flag", {63'h0, misalign_err}, 64'h1);
    br_target = 64'h0;
    step();
    check("mis2_addr", imem_addr, 64'h0);
    check("mis_sticky", {63'h0, misalign_err}, 64'h1);
    br_taken = 1'b0;

    // Halt word at 0x10: fetch 0,4,8,C then stop.
    halt_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_ifid("pre_halt", 64'hC, 1'b1, 32'd9);
    step();
    check("halt_flag", {63'h0, halted}, 64'h1);
    check_ifid("halt", 64'hC, 1'b0, 32'd9);
    check("halt_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; flush = ~i[0];
      step();
      check("halt_addr", imem_addr, 64'h10);
      check("halt_hold", {63'h0, halted}, 64'h1);
      check("halt_bubble", {63'h0, if_id_valid}, 64'h0);
    end
    stall = 1'b0; flush = 1'b0;

    // Wrong-path halt: branch out to 0x40.
    br_taken = 1'b1; br_target = 64'h40;
    step();
    check("unhalt_flag", {63'h0, halted}, 64'h0);
    check("unhalt_addr", imem_addr, 64'h40);
    check("unhalt_valid", {63'h0, if_id_valid}, 64'h0);
    br_taken = 1'b0;
    step();
    check_ifid("f40", 64'h40, 1'b1, 32'd10);
    check("f40_instr", {32'h0, if_id_instr}, 64'h40);

    // Reset while halted.
    br_taken = 1'b1; br_target = 64'h10;
    step();
    br_taken = 1'b0;
    step();
    check("halt2_flag", {63'h0, halted}, 64'h1);
    reset = 1'b1;
    step();
    check_reset_state("rst_halt");

    // Reset while stalled.
    reset = 1'b0; halt_en = 1'b0;
    step(); step(); step();
    check_ifid("refetch", 64'h4, 1'b1, 32'd2);
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    check_reset_state("rst_stall");
    reset = 1'b0; stall = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
